adder_64: RTL and testbench

- Pipelined 64-bit binary adder with carry-in and carry-out. Throughput is one operation per clock.
- The carry ripples through fixed-width segments, one segment per pipeline stage, to keep the critical path short.
- Integer datapath building block. It takes a valid-qualified input bus and returns a ready-qualified result, with a global enable that stalls the whole pipeline.

---
 rtl/adder_64_pkg.sv | 13 +
 rtl/adder_64_if.sv | 17 +
 rtl/adder_64_seg.sv | 16 +
 rtl/adder_64.sv | 110 +++++++++++
 tb/tb_adder_64.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_64_pkg.sv
// adder_64_pkg: shared widths for the pipelined 64-bit adder.
//   LEN_DATA : operand/sum width (overridable through the `LEN_DATA define)
//   SEG_W    : bits added per pipeline stage
//   NSEG     : number of segments == number of pipeline stages
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

package adder_64_pkg;
   localparam int LEN_DATA = `LEN_DATA;
   localparam int SEG_W    = 16;
   localparam int NSEG     = LEN_DATA / SEG_W;
endpackage

// File: rtl/adder_64_if.sv
// adder_64_if: operand/result bus of the pipelined adder.
//   valid, a, b, cin : new operation (driven by master)
//   sum, cout, rdy   : registered result and its one-cycle strobe (driven by slave)
interface adder_64_if;
   import adder_64_pkg::*;

   logic                valid;
   logic [LEN_DATA-1:0] a;
   logic [LEN_DATA-1:0] b;
   logic                cin;
   logic [LEN_DATA-1:0] sum;
   logic                cout;
   logic                rdy;

   modport master (output valid, a, b, cin, input  sum, cout, rdy);
   modport slave  (input  valid, a, b, cin, output sum, cout, rdy);
endinterface

// File: rtl/adder_64_seg.sv
// adder_64_seg: purely combinational W-bit add slice.
//   x_i, y_i : segment operands
//   ci_i     : carry into the segment
//   s_o      : segment sum
//   co_o     : carry out of the segment
module adder_64_seg #(
   parameter int W = 16
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);
   assign {co_o, s_o} = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, ci_i};
endmodule

// File: rtl/adder_64.sv
// adder_64: pipelined LEN_DATA-bit adder, one SEG_W-bit segment per stage.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-low reset, dominates en
//   en  : global enable, 0 freezes every register
//   bus : slave side of adder_64_if (valid/a/b/cin in, sum/cout/rdy out)
// An operation captured at enabled edge t produces sum/cout/rdy at enabled
// edge t+NSEG-1. Stages 0..NSEG-2 own a pipeline register; the last stage
// adds combinationally from stage NSEG-2 straight into the output registers.
module adder_64
   import adder_64_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   adder_64_if.slave  bus
);
   logic [LEN_DATA-1:0] sum_d, sum_q;
   logic                cout_d, cout_q;
   logic                rdy_d, rdy_q;

   genvar gi;
   for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam int LO = gi * SEG_W;        // first bit of this stage's segment
      localparam int HI = (gi + 1) * SEG_W;  // first bit still to be added after this stage

      logic [SEG_W-1:0] seg_x, seg_y, seg_s;
      logic             seg_ci, seg_co, seg_v;

      // Stage 0 adds straight off the input bus; later stages read the
      // skewed operand segment and the carry registered by the stage before.
      if (gi == 0) begin : g_src
         assign seg_x  = bus.a[SEG_W-1:0];
         assign seg_y  = bus.b[SEG_W-1:0];
         assign seg_ci = bus.cin;
         assign seg_v  = bus.valid;
      end else begin : g_src
         assign seg_x  = g_stage[gi-1].g_reg.a_q[LO +: SEG_W];
         assign seg_y  = g_stage[gi-1].g_reg.b_q[LO +: SEG_W];
         assign seg_ci = g_stage[gi-1].g_reg.c_q;
         assign seg_v  = g_stage[gi-1].g_reg.v_q;
      end

      adder_64_seg #(.W(SEG_W)) u_seg (
         .x_i  (seg_x),
         .y_i  (seg_y),
         .ci_i (seg_ci),
         .s_o  (seg_s),
         .co_o (seg_co)
      );

      if (gi < NSEG - 1) begin : g_reg
         // Skew registers hold only the operand bits not yet added; deskew
         // registers hold only the sum bits already finished.
         logic [LEN_DATA-1:HI] a_d, a_q;
         logic [LEN_DATA-1:HI] b_d, b_q;
         logic [HI-1:0]        s_d, s_q;
         logic                 c_q, v_q;

         if (gi == 0) begin : g_fwd
            assign a_d = bus.a[LEN_DATA-1:HI];
            assign b_d = bus.b[LEN_DATA-1:HI];
            assign s_d = seg_s;
         end else begin : g_fwd
            assign a_d = g_stage[gi-1].g_reg.a_q[LEN_DATA-1:HI];
            assign b_d = g_stage[gi-1].g_reg.b_q[LEN_DATA-1:HI];
            assign s_d = {seg_s, g_stage[gi-1].g_reg.s_q};
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (en) begin
               a_q <= a_d;
               b_q <= b_d;
               s_q <= s_d;
               c_q <= seg_co;
               v_q <= seg_v;
            end
         end
      end else begin : g_out
         assign sum_d  = {seg_s, g_stage[gi-1].g_reg.s_q};
         assign cout_d = seg_co;
         assign rdy_d  = seg_v;
      end
   end

   // Result registers only load behind a valid op, so bubbles leave the
   // previous sum/cout visible while rdy drops to 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         rdy_q  <= 1'b0;
      end else if (en) begin
         rdy_q <= rdy_d;
         if (rdy_d) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
         end
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.rdy  = rdy_q;
endmodule

// File: tb/tb_adder_64.sv
module tb_adder_64;
   import adder_64_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic en;

   adder_64_if bus ();

   adder_64 dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [LEN_DATA:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [LEN_DATA-1:0] a, input logic [LEN_DATA-1:0] b,
                        input logic c);
      bus.valid = v;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = c;
   endtask

   function automatic logic [LEN_DATA-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // ---------------------------------------------------------------- reset
   task automatic test_reset();
      logic [LEN_DATA:0] e;
      int edges;
      bit got;
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
         tick();
         n_cmp++;
         if ({bus.rdy, bus.cout, bus.sum} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold cycle %0d: rdy=%b cout=%b sum=%h, required all 0",
                     i, bus.rdy, bus.cout, bus.sum);
         end
      end
      rst = 1'b1;
      drive(1'b1, 64'd123, 64'd456, 1'b1);
      exp_q.push_back(65'd580);
      tick();
      edges = 1;
      drive(1'b0, '0, '0, 1'b0);
      got = 1'b0;
      while (edges < 12 && !got) begin
         tick();
         edges++;
         if (bus.rdy) got = 1'b1;
      end
      n_cmp++;
      if (!got || edges != 4) begin
         n_bad++;
         $display("FAIL reset_latency: first rdy at edge %0d (seen=%0d), required edge 4", edges, got);
      end
      if (got) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus.cout, bus.sum} !== e) begin
            n_bad++;
            $display("FAIL reset_first_op: got %h, required %h", {bus.cout, bus.sum}, e);
         end else $display("txn reset_first_op: cout=%b sum=%h", bus.cout, bus.sum);
      end else exp_q.delete();
   endtask

   // --------------------------------------------------------- carry ripple
   task automatic test_full_ripple();
      logic [LEN_DATA:0] e;
      int rdys = 0;
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      exp_q.push_back({1'b1, 64'h0});
      tick();
      drive(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
      exp_q.push_back({1'b0, 64'h0000_0001_0000_0000});
      tick();
      drive(1'b0, '0, '0, 1'b0);
      for (int t = 0; t < 8; t++) begin
         tick();
         if (bus.rdy) begin
            rdys++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL ripple_extra_rdy: got sum=%h, required no rdy", bus.sum);
            end else begin
               e = exp_q.pop_front();
               if ({bus.cout, bus.sum} !== e) begin
                  n_bad++;
                  $display("FAIL ripple_result: got %h, required %h", {bus.cout, bus.sum}, e);
               end else $display("txn ripple: cout=%b sum=%h", bus.cout, bus.sum);
            end
         end
      end
      n_cmp++;
      if (rdys != 2 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL ripple_count: got %0d rdy pulses (%0d left), required 2 (0 left)",
                  rdys, exp_q.size());
      end
      exp_q.delete();
   endtask

   // ----------------------------------------------- back-to-back + bubble
   task automatic test_back_to_back();
      logic              v_t[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [LEN_DATA-1:0] a_t[4] = '{64'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd5};
      logic [LEN_DATA-1:0] b_t[4] = '{64'd2, 64'h8000_0000_0000_0000, 64'd0, 64'd7};
      logic              rdy_t[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [LEN_DATA:0] e;
      for (int t = 0; t < 8; t++) begin
         if (t < 4) begin
            drive(v_t[t], a_t[t], b_t[t], 1'b0);
            if (v_t[t]) exp_q.push_back({1'b0, a_t[t]} + {1'b0, b_t[t]});
         end else drive(1'b0, '0, '0, 1'b0);
         tick();
         n_cmp++;
         if (bus.rdy !== rdy_t[t]) begin
            n_bad++;
            $display("FAIL b2b_rdy t=%0d: got %b, required %b", t, bus.rdy, rdy_t[t]);
         end
         if (t == 5) begin
            n_cmp++;
            if ({bus.cout, bus.sum} !== {1'b1, 64'h0}) begin
               n_bad++;
               $display("FAIL b2b_bubble_hold: got %h, required %h", {bus.cout, bus.sum}, {1'b1, 64'h0});
            end
         end
         if (bus.rdy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.cout, bus.sum} !== e) begin
               n_bad++;
               $display("FAIL b2b_result t=%0d: got %h, required %h", t, {bus.cout, bus.sum}, e);
            end else $display("txn b2b: cout=%b sum=%h", bus.cout, bus.sum);
         end
      end
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- stall
   task automatic test_stall();
      logic rdy_t[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [LEN_DATA:0] e;
      for (int t = 0; t < 11; t++) begin
         en = !(t >= 4 && t <= 6);
         if (t == 0) begin
            drive(1'b1, 64'd100, 64'd200, 1'b0);
            exp_q.push_back(65'd300);
         end else if (t == 2) begin
            drive(1'b1, 64'd10, 64'd20, 1'b1);
            exp_q.push_back(65'd31);
         end else drive(1'b0, '0, '0, 1'b0);
         tick();
         n_cmp++;
         if (bus.rdy !== rdy_t[t]) begin
            n_bad++;
            $display("FAIL stall_rdy t=%0d: got %b, required %b", t, bus.rdy, rdy_t[t]);
         end
         if (t >= 4 && t <= 7) begin
            n_cmp++;
            if ({bus.cout, bus.sum} !== 65'd300) begin
               n_bad++;
               $display("FAIL stall_frozen t=%0d: got %h, required %h", t, {bus.cout, bus.sum}, 65'd300);
            end
         end
         if (en && bus.rdy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.cout, bus.sum} !== e) begin
               n_bad++;
               $display("FAIL stall_result t=%0d: got %h, required %h", t, {bus.cout, bus.sum}, e);
            end else $display("txn stall: cout=%b sum=%h", bus.cout, bus.sum);
         end
      end
      en = 1'b1;
      exp_q.delete();
   endtask

   // ------------------------------------------------- reset mid-operation
   task automatic test_reset_mid();
      logic              rdy_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [LEN_DATA:0] res_t[8] = '{65'd0, 65'd0, 65'd0, 65'd0, 65'd0, 65'd0, 65'd7, 65'd7};
      for (int t = 0; t < 8; t++) begin
         rst = (t == 2) ? 1'b0 : 1'b1;
         case (t)
            0:       drive(1'b1, 64'd7, 64'd8, 1'b0);
            1:       drive(1'b1, 64'd9, 64'd9, 1'b0);
            3:       drive(1'b1, 64'd3, 64'd4, 1'b0);
            default: drive(1'b0, '0, '0, 1'b0);
         endcase
         tick();
         if (t >= 2) begin
            n_cmp++;
            if (bus.rdy !== rdy_t[t] || {bus.cout, bus.sum} !== res_t[t]) begin
               n_bad++;
               $display("FAIL rst_mid t=%0d: got rdy=%b res=%h, required rdy=%b res=%h",
                        t, bus.rdy, {bus.cout, bus.sum}, rdy_t[t], res_t[t]);
            end else if (bus.rdy) $display("txn rst_mid: cout=%b sum=%h", bus.cout, bus.sum);
         end
      end
      rst = 1'b1;
   endtask

   // --------------------------------------------------------------- random
   task automatic test_random();
      logic [31:0]         r1, r2;
      logic [LEN_DATA-1:0] a, b;
      logic                c;
      logic [LEN_DATA:0]   e;
      int                  nres = 0;
      for (int i = 0; i < 1240; i++) begin
         if (i < 1230 && (i % 2) == 0) begin
            r1 = $urandom;
            r2 = $urandom;
            a  = {{32{r1[31]}}, r1};
            b  = {{32{r2[31]}}, r2};
            c  = 1'($urandom_range(0, 1));
            drive(1'b1, a, b, c);
            exp_q.push_back({1'b0, a} + {1'b0, b} + {{LEN_DATA{1'b0}}, c});
         end else drive(1'b0, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
         tick();
         if (bus.rdy) begin
            n_cmp++;
            nres++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL rand_extra_rdy: got sum=%h, required no rdy", bus.sum);
            end else begin
               e = exp_q.pop_front();
               if ({bus.cout, bus.sum} !== e) begin
                  n_bad++;
                  $display("FAIL rand_result #%0d: got %h, required %h", nres, {bus.cout, bus.sum}, e);
               end else $display("txn rand #%0d: cout=%b sum=%h", nres, bus.cout, bus.sum);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rand_drain: got %0d results outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      test_reset();
      test_full_ripple();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
